output_port_scheduler: RTL and testbench
========================================

# output_port_scheduler

Round-robin scheduler for one router output port. It arbitrates among the five flit sources (North, South, East, West, local cache bank) with a valid/ready handshake and buffers granted flits in a small FIFO. It drains the FIFO onto the output link under credit-based flow control from the downstream router. One instance sits in front of each router output link.

## Interface
- NUM_REQ, 5, number of requesters; index 0 N, 1 S, 2 E, 3 W, 4 cache
- FLIT_WIDTH, `NETWORK_ADDRESS_WIDTH+`CACHE_BANK_ADDRESS_WIDTH+`NETWORK_ADDRESS_WIDTH+2+`DATA_WIDTH, packed flit {dest, requester, read, write, data}
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2
- CREDITS, 4, downstream buffer slots, 1..15
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  requester i presents a flit
- req_flit  in  NUM_REQ*FLIT_WIDTH  flit i at bits [i*FLIT_WIDTH +: FLIT_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant (or zero); transfer when req_valid[i] & req_ready[i]
- out_valid  out  1  out_flit valid this cycle, one cycle per flit
- out_flit  out  FLIT_WIDTH  flit to downstream link
- credit_in  in  1  downstream freed one slot (single-cycle pulse)
- credits_avail  out  4  current credit count
- fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- credit_overflow  out  1  sticky error: credit_in arrived while credits_avail == CREDITS

## Operation
- Arbiter (combinational grant, registered pointer): when fifo_count < FIFO_DEPTH, grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NUM_REQ. At most one grant per cycle. Full FIFO → req_ready = 0.
- On transfer from index g: push req_flit[g]; rr_ptr ← (g+1) mod NUM_REQ. No transfer → rr_ptr unchanged.
- req_ready depends only on registered state and req_valid. Requesters must hold req_valid and the flit until granted.
- Drain: when FIFO is non-empty and credits_avail > 0, pop the head into out_flit and set out_valid = 1 next cycle. Otherwise out_valid = 0; out_flit holds its last value.
- Credits: next = credits_avail + credit_in − pop.
  - credit_in while at CREDITS with no same-cycle pop: count stays at CREDITS and credit_overflow sets. It stays set until reset.
  - credit_in at CREDITS with a same-cycle pop: count stays at CREDITS; not an error.
- FIFO: push and pop in the same cycle are both legal when non-empty and not full; occupancy is unchanged. The full/empty decision uses pre-edge occupancy. There is no bypass from request to output. Pointers wrap mod FIFO_DEPTH.
- Reset values: out_valid 0, out_flit 0, req_ready reflects empty FIFO, rr_ptr 0, fifo_count 0, credits_avail CREDITS, credit_overflow 0, FIFO pointers 0.
- Reset asserted mid-operation discards buffered flits and in-flight credits. Reset dominates push, pop and credit_in in the same cycle.

## Timing
- Minimum latency: transfer at edge k → flit in FIFO → popped at edge k+1 → out_valid high during cycle k+1..k+2. That is 2 edges from the first cycle req_valid is sampled with req_ready.
- Sustained throughput is one flit per cycle while credits never reach 0. The credit round trip is outside this block.
- With all five requesters continuously valid, each is granted exactly once per 5 consecutive grants.
- The grant path is combinational from req_valid to req_ready within one cycle. There are no other combinational input-to-output paths.

## Structure
- The shared include (globalVariables.v) holds:
  - port index constants PORT_NORTH=0, PORT_SOUTH=1, PORT_EAST=2, PORT_WEST=3, PORT_CACHE=4
  - flit field widths and offsets
  - the default FLIT_WIDTH expression
- One sub-module, flit_fifo: a synchronous FIFO parameterised on width and depth, with push, pop, full, empty and count outputs. The arbiter, rr_ptr and credit counter live in output_port_scheduler.

## Test plan
- After reset: out_valid=0, credits_avail=4, fifo_count=0, credit_overflow=0. req_valid=5'b00001 → req_ready=5'b00001 that cycle; out_valid=1 two edges later with the same flit.
- req_valid=5'b11111 held, credit_in pulsed every cycle → grant order 0,1,2,3,4,0,… ; out_valid every cycle after fill.
- No credit_in, single requester valid continuously: 4 flits on out, then credits_avail=0 and out_valid=0. fifo_count reaches 4, then req_ready=0. One credit_in pulse → exactly one more out flit, and fifo_count drops to 3.
- rr_ptr=3 with req_valid=5'b00101 → grant index 0 (wrap), then rr_ptr=1 → next grant index 2.
- credit_in pulsed with credits_avail=4 and FIFO empty → credits_avail stays 4 and credit_overflow=1, sticky until reset.
- Reset asserted with fifo_count=3 and credits_avail=1 → next cycle fifo_count=0, credits_avail=4, out_valid=0, rr_ptr=0; buffered flits never appear.

Source files
------------

// File: rtl/output_port_scheduler_pkg.sv
// Shared constants, flit layout and round-robin helper for the output port scheduler.
package output_port_scheduler_pkg;

    // Flit field widths
    localparam int unsigned NETWORK_ADDRESS_WIDTH    = 4;
    localparam int unsigned CACHE_BANK_ADDRESS_WIDTH = 4;
    localparam int unsigned DATA_WIDTH               = 16;

    // Requester port indices
    localparam int unsigned PORT_NORTH = 0;
    localparam int unsigned PORT_SOUTH = 1;
    localparam int unsigned PORT_EAST  = 2;
    localparam int unsigned PORT_WEST  = 3;
    localparam int unsigned PORT_CACHE = 4;

    localparam int unsigned NUM_REQ    = 5;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CREDITS    = 4;

    localparam int unsigned FLIT_WIDTH = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH
                                       + NETWORK_ADDRESS_WIDTH + 2 + DATA_WIDTH;
    localparam int unsigned PTR_W      = $clog2(NUM_REQ);
    localparam int unsigned COUNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CREDIT_W   = 4;

    // Flit layout: {dest, requester, read, write, data}
    typedef struct packed {
        logic [NETWORK_ADDRESS_WIDTH-1:0]    dest_node;
        logic [CACHE_BANK_ADDRESS_WIDTH-1:0] dest_bank;
        logic [NETWORK_ADDRESS_WIDTH-1:0]    requester;
        logic                                read;
        logic                                write;
        logic [DATA_WIDTH-1:0]               data;
    } flit_t;

    // Requester index reached by stepping 'offset' places from 'base', modulo NUM_REQ
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                  input int unsigned     offset);
        int unsigned w_sum;
        w_sum = 32'(base) + offset;
        return PTR_W'(w_sum % NUM_REQ);
    endfunction

endpackage

// File: rtl/output_port_scheduler_if.sv
// Requester, output-link and status signals of one scheduler instance.
interface output_port_scheduler_if;
    import output_port_scheduler_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    flit_t                         out_flit;
    logic                          credit_in;
    logic [CREDIT_W-1:0]           credits_avail;
    logic [COUNT_W-1:0]            fifo_count;
    logic                          credit_overflow;

    // Environment side: requesters and downstream router
    modport master (
        output req_valid, req_flit, credit_in,
        input  req_ready, out_valid, out_flit, credits_avail, fifo_count, credit_overflow
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_flit, credit_in,
        output req_ready, out_valid, out_flit, credits_avail, fifo_count, credit_overflow
    );
endinterface

// File: rtl/output_port_scheduler_flit_fifo.sv
// Synchronous FIFO with count; push ignored when full, pop ignored when empty.
module flit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and occupancy update; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Round-robin arbiter over five flit sources feeding a FIFO drained under credit flow control.
module output_port_scheduler
    import output_port_scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    output_port_scheduler_if.slave   bus
);

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [CREDIT_W-1:0]   r_credits;
    logic                  r_overflow;
    logic                  r_out_valid;
    flit_t                 r_out_flit;

    logic                  w_full;
    logic                  w_empty;
    logic [COUNT_W-1:0]    w_count;
    logic [FLIT_WIDTH-1:0] w_head;
    logic [FLIT_WIDTH-1:0] w_push_flit;
    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [PTR_W-1:0]      w_scan_idx;
    logic                  w_push;
    logic                  w_pop;

    // Grant the first valid requester at or after rr_ptr while the FIFO has room
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_push      = 1'b0;
        w_scan_idx  = '0;
        if (!w_full) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                w_scan_idx = rr_index(r_rr_ptr, k);
                if (!w_push && bus.req_valid[w_scan_idx]) begin
                    w_grant[w_scan_idx] = 1'b1;
                    w_grant_idx         = w_scan_idx;
                    w_push              = 1'b1;
                end
            end
        end
    end

    assign w_push_flit   = bus.req_flit[32'(w_grant_idx)*FLIT_WIDTH +: FLIT_WIDTH];
    assign w_pop         = !w_empty && (r_credits != '0);

    assign bus.req_ready       = w_grant;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_flit        = r_out_flit;
    assign bus.credits_avail   = r_credits;
    assign bus.fifo_count      = w_count;
    assign bus.credit_overflow = r_overflow;

    flit_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_flit),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Round-robin pointer advances past the winner only on a transfer
    always_ff @(posedge clk) begin
        if (reset)       r_rr_ptr <= '0;
        else if (w_push) r_rr_ptr <= rr_index(w_grant_idx, 1);
    end

    // Credit count saturates at CREDITS; a surplus credit with no pop is a sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits  <= CREDIT_W'(CREDITS);
            r_overflow <= 1'b0;
        end else if (bus.credit_in && !w_pop) begin
            if (r_credits == CREDIT_W'(CREDITS)) r_overflow <= 1'b1;
            else                                 r_credits  <= r_credits + CREDIT_W'(1);
        end else if (!bus.credit_in && w_pop) begin
            r_credits <= r_credits - CREDIT_W'(1);
        end
    end

    // Output link register; flit holds its last value when nothing is popped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop) r_out_flit <= flit_t'(w_head);
        end
    end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Randomised and directed bench for output_port_scheduler against a queue-based model.
module tb_output_port_scheduler;
    import output_port_scheduler_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    output_port_scheduler_if bus();

    output_port_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [FLIT_WIDTH-1:0] m_q[$];
    int                    m_credits;
    int                    m_ptr;
    logic                  m_ovf;
    logic                  m_out_valid;
    logic [FLIT_WIDTH-1:0] m_out_flit;
    logic [FLIT_WIDTH-1:0] cur_flit [NUM_REQ];
    logic [NUM_REQ-1:0]    obs_ready;
    logic [NUM_REQ-1:0]    exp_ready;

    function automatic logic [FLIT_WIDTH-1:0] new_flit();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return FLIT_WIDTH'(r);
    endfunction

    // One clock: drive at negedge, sample grant, advance model at posedge, return at next negedge
    task automatic step(input logic [NUM_REQ-1:0] v, input logic c, input logic rst);
        int g;
        int idx;
        int pop;
        bus.req_valid = v;
        bus.credit_in = c;
        reset         = rst;
        for (int i = 0; i < NUM_REQ; i++) bus.req_flit[i*FLIT_WIDTH +: FLIT_WIDTH] = cur_flit[i];
        g = -1;
        if (m_q.size() < FIFO_DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        #1;
        obs_ready = bus.req_ready;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_credits   = CREDITS;
            m_ptr       = 0;
            m_ovf       = 1'b0;
            m_out_valid = 1'b0;
            m_out_flit  = '0;
        end else begin
            pop = (m_q.size() > 0 && m_credits > 0) ? 1 : 0;
            m_out_valid = (pop == 1);
            if (pop == 1) m_out_flit = m_q.pop_front();
            m_credits = m_credits + (c ? 1 : 0) - pop;
            if (m_credits > CREDITS) begin
                m_credits = CREDITS;
                m_ovf     = 1'b1;
            end
            if (g >= 0) begin
                m_q.push_back(cur_flit[g]);
                m_ptr       = (g + 1) % NUM_REQ;
                cur_flit[g] = new_flit();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        logic [FLIT_WIDTH-1:0] f0;
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.credits_avail !== CREDIT_W'(4)) begin errors++; $display("FAIL reset_credits got %0d want 4", bus.credits_avail); end
        checks++; if (bus.fifo_count !== COUNT_W'(0)) begin errors++; $display("FAIL reset_fifo_count got %0d want 0", bus.fifo_count); end
        checks++; if (bus.credit_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.credit_overflow); end
        f0 = cur_flit[0];
        step(5'b00001, 1'b0, 1'b0);
        checks++; if (obs_ready !== 5'b00001) begin errors++; $display("FAIL first_grant got %b want 00001", obs_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", bus.out_valid); end
        step(5'b00000, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_flit !== f0) begin errors++; $display("FAIL latency_flit got %h want %h", bus.out_flit, f0); end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] want;
        do_reset();
        for (int n = 0; n < 15; n++) begin
            step(5'b11111, (n >= 1), 1'b0);
            want = '0;
            want[n % NUM_REQ] = 1'b1;
            checks++; if (obs_ready !== want) begin errors++; $display("FAIL rr_grant n=%0d got %b want %b", n, obs_ready, want); end
            if (n >= 1) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rr_stream n=%0d got %b want 1", n, bus.out_valid); end
                checks++; if (bus.out_flit !== m_out_flit) begin errors++; $display("FAIL rr_flit n=%0d got %h want %h", n, bus.out_flit, m_out_flit); end
            end
        end
        checks++; if (bus.credits_avail !== CREDIT_W'(4)) begin errors++; $display("FAIL rr_credits got %0d want 4", bus.credits_avail); end
        checks++; if (bus.credit_overflow !== 1'b0) begin errors++; $display("FAIL rr_no_overflow got %b want 0", bus.credit_overflow); end
    endtask

    task automatic test_credit_starve();
        int n_out;
        do_reset();
        n_out = 0;
        for (int n = 0; n < 10; n++) begin
            step(5'b00001, 1'b0, 1'b0);
            if (bus.out_valid === 1'b1) begin
                n_out++;
                checks++; if (bus.out_flit !== m_out_flit) begin errors++; $display("FAIL starve_flit got %h want %h", bus.out_flit, m_out_flit); end
            end
        end
        checks++; if (n_out != 4) begin errors++; $display("FAIL starve_out_count got %0d want 4", n_out); end
        checks++; if (bus.credits_avail !== CREDIT_W'(0)) begin errors++; $display("FAIL starve_credits got %0d want 0", bus.credits_avail); end
        checks++; if (bus.fifo_count !== COUNT_W'(4)) begin errors++; $display("FAIL starve_full got %0d want 4", bus.fifo_count); end
        step(5'b00001, 1'b0, 1'b0);
        checks++; if (obs_ready !== 5'b00000) begin errors++; $display("FAIL starve_ready got %b want 00000", obs_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL starve_idle got %b want 0", bus.out_valid); end
        step(5'b00001, 1'b1, 1'b0);
        checks++; if (bus.credits_avail !== CREDIT_W'(1)) begin errors++; $display("FAIL starve_credit_back got %0d want 1", bus.credits_avail); end
        step(5'b00001, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL starve_one_more got %b want 1", bus.out_valid); end
        checks++; if (bus.out_flit !== m_out_flit) begin errors++; $display("FAIL starve_one_flit got %h want %h", bus.out_flit, m_out_flit); end
        checks++; if (bus.fifo_count !== COUNT_W'(3)) begin errors++; $display("FAIL starve_drop got %0d want 3", bus.fifo_count); end
        n_out = 0;
        for (int n = 0; n < 3; n++) begin
            step(5'b00000, 1'b0, 1'b0);
            if (bus.out_valid === 1'b1) n_out++;
        end
        checks++; if (n_out != 0) begin errors++; $display("FAIL starve_extra got %0d want 0", n_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(5'b00100, 1'b0, 1'b0);
        checks++; if (obs_ready !== 5'b00100) begin errors++; $display("FAIL wrap_setup got %b want 00100", obs_ready); end
        step(5'b00101, 1'b0, 1'b0);
        checks++; if (obs_ready !== 5'b00001) begin errors++; $display("FAIL wrap_grant got %b want 00001", obs_ready); end
        step(5'b00101, 1'b0, 1'b0);
        checks++; if (obs_ready !== 5'b00100) begin errors++; $display("FAIL wrap_next got %b want 00100", obs_ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        step(5'b00000, 1'b1, 1'b0);
        checks++; if (bus.credit_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.credit_overflow); end
        checks++; if (bus.credits_avail !== CREDIT_W'(4)) begin errors++; $display("FAIL ovf_credits got %0d want 4", bus.credits_avail); end
        for (int n = 0; n < 3; n++) begin
            step(5'b00000, 1'b0, 1'b0);
            checks++; if (bus.credit_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky n=%0d got %b want 1", n, bus.credit_overflow); end
        end
        step(5'b00000, 1'b0, 1'b1);
        checks++; if (bus.credit_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", bus.credit_overflow); end
    endtask

    task automatic test_reset_mid();
        int n_out;
        do_reset();
        for (int n = 0; n < 7; n++) step(5'b00001, 1'b0, 1'b0);
        step(5'b00000, 1'b1, 1'b0);
        checks++; if (bus.fifo_count !== COUNT_W'(3)) begin errors++; $display("FAIL mid_setup_fifo got %0d want 3", bus.fifo_count); end
        checks++; if (bus.credits_avail !== CREDIT_W'(1)) begin errors++; $display("FAIL mid_setup_credits got %0d want 1", bus.credits_avail); end
        step(5'b00001, 1'b1, 1'b1);
        checks++; if (bus.fifo_count !== COUNT_W'(0)) begin errors++; $display("FAIL mid_fifo got %0d want 0", bus.fifo_count); end
        checks++; if (bus.credits_avail !== CREDIT_W'(4)) begin errors++; $display("FAIL mid_credits got %0d want 4", bus.credits_avail); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
        n_out = 0;
        for (int n = 0; n < 4; n++) begin
            step(5'b00000, 1'b0, 1'b0);
            if (bus.out_valid === 1'b1) n_out++;
        end
        checks++; if (n_out != 0) begin errors++; $display("FAIL mid_stale_flits got %0d want 0", n_out); end
        step(5'b11111, 1'b0, 1'b0);
        checks++; if (obs_ready !== 5'b00001) begin errors++; $display("FAIL mid_rr_ptr got %b want 00001", obs_ready); end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend;
        logic               c;
        do_reset();
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!pend[i] && ($urandom % 3 == 0)) pend[i] = 1'b1;
            c = ($urandom % 3 == 0);
            step(pend, c, 1'b0);
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready n=%0d got %b want %b", n, obs_ready, exp_ready); end
            checks++; if (bus.out_valid !== m_out_valid) begin errors++; $display("FAIL rand_valid n=%0d got %b want %b", n, bus.out_valid, m_out_valid); end
            checks++; if (bus.out_flit !== m_out_flit) begin errors++; $display("FAIL rand_flit n=%0d got %h want %h", n, bus.out_flit, m_out_flit); end
            checks++; if (bus.fifo_count !== COUNT_W'(m_q.size())) begin errors++; $display("FAIL rand_count n=%0d got %0d want %0d", n, bus.fifo_count, m_q.size()); end
            checks++; if (bus.credits_avail !== CREDIT_W'(m_credits)) begin errors++; $display("FAIL rand_credits n=%0d got %0d want %0d", n, bus.credits_avail, m_credits); end
            checks++; if (bus.credit_overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf n=%0d got %b want %b", n, bus.credit_overflow, m_ovf); end
            pend = pend & ~exp_ready;
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_flit  = '0;
        bus.credit_in = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) cur_flit[i] = new_flit();
        m_q.delete();
        m_credits   = CREDITS;
        m_ptr       = 0;
        m_ovf       = 1'b0;
        m_out_valid = 1'b0;
        m_out_flit  = '0;
        test_reset();
        test_round_robin();
        test_credit_starve();
        test_wrap();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
